// File: rtl/paddsb_arb_pkg.sv
// Shared definitions for the paddsb_arbiter slice.
//   NUM_LANES / VEC_W : packed nibble layout of the 16-bit operands
//   NIB_POS_SAT/NEG   : per-nibble saturation values
//   req_id_t          : requester index (two requesters)
//   out_state_t       : output register occupancy
package paddsb_arb_pkg;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  localparam logic [VEC_W-1:0] NIB_POS_SAT = 4'b0111;
  localparam logic [VEC_W-1:0] NIB_NEG_SAT = 4'b1000;

  typedef logic req_id_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;
endpackage

// File: rtl/paddsb_16.sv
// 16-bit saturating packed nibble adder: four independent lanes,
// no carry between nibbles.
//   a, b : packed operands   sub : add/sub select   sum : packed result
module paddsb_16
  import paddsb_arb_pkg::*;
(
  input  logic [NUM_LANES-1:0][VEC_W-1:0] a,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] b,
  input  logic                            sub,
  output logic [NUM_LANES-1:0][VEC_W-1:0] sum
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    paddsb_lane u_lane (
      .a   (a[l]),
      .b   (b[l]),
      .sub (sub),
      .sum (sum[l])
    );
  end
endmodule

// File: rtl/paddsb_lane.sv
// One 4-bit two's-complement saturating add/sub lane.
//   a, b : operands
//   sub  : 1 = a-b, 0 = a+b
//   sum  : saturated result
module paddsb_lane
  import paddsb_arb_pkg::*;
(
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  input  logic             sub,
  output logic [VEC_W-1:0] sum
);
  logic [VEC_W:0] raw;

  // One guard bit: the top two bits disagree exactly on overflow,
  // and bit VEC_W gives the true sign of the unclamped result.
  always_comb begin
    raw = sub ? ({a[VEC_W-1], a} - {b[VEC_W-1], b})
              : ({a[VEC_W-1], a} + {b[VEC_W-1], b});
    if (raw[VEC_W:VEC_W-1] == 2'b01)      sum = NIB_POS_SAT;
    else if (raw[VEC_W:VEC_W-1] == 2'b10) sum = NIB_NEG_SAT;
    else                                  sum = raw[VEC_W-1:0];
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with last-accepted pointer.
//   clk, rst_n : clock, synchronous active-low reset
//   vld        : request vector
//   en         : grant enable (output slot free and not in reset)
//   rdy        : one-hot (or zero) accept vector
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vld,
  input  logic       en,
  output logic [1:0] rdy
);
  logic last_q;  // index of last accepted requester
  logic [1:0] gnt;

  always_comb begin
    gnt = vld;
    // Tie goes to whoever did not win last time.
    if (&vld) gnt = last_q ? 2'b01 : 2'b10;
    rdy = gnt & {2{en}};
  end

  // Reset to "last=1" so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (|rdy) last_q <= rdy[1];
  end
endmodule

// File: rtl/paddsb_arbiter.sv
// Two-requester arbiter in front of a saturating packed nibble add/sub
// with a single registered result slot and valid/ready handshake.
//   clk, rst_n            : clock, synchronous active-low reset
//   vld0/1, A0/1, B0/1, sub0/1 : requests (held until accepted)
//   rdy0/1                : request accepted this cycle
//   res_vld/res_Sum/res_id: result register, res_rdy consumer accept
//   gnt_cnt0/1            : saturating accept counters
// Optional feature: define PADDSB_ARB_CNT_EN to build the grant
// counters; otherwise they read zero.
module paddsb_arbiter
  import paddsb_arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld0,
  input  logic             vld1,
  input  logic [15:0]      A0,
  input  logic [15:0]      B0,
  input  logic [15:0]      A1,
  input  logic [15:0]      B1,
  input  logic             sub0,
  input  logic             sub1,
  output logic             rdy0,
  output logic             rdy1,
  output logic             res_vld,
  output logic [15:0]      res_Sum,
  output logic             res_id,
  input  logic             res_rdy,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  out_state_t state_q, state_d;
  logic [1:0]  rdy;
  logic        free, xfer;
  logic [15:0] op_a, op_b, sum;
  logic        op_sub;
  req_id_t     id_q;
  logic [15:0] sum_q;

  assign free = (state_q == OUT_EMPTY) | res_rdy;

  // rst_n in the enable keeps both rdy low during reset.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   ({vld1, vld0}),
    .en    (free & rst_n),
    .rdy   (rdy)
  );

  assign rdy0 = rdy[0];
  assign rdy1 = rdy[1];
  assign xfer = |rdy;

  assign op_a   = rdy[1] ? A1   : A0;
  assign op_b   = rdy[1] ? B1   : B0;
  assign op_sub = rdy[1] ? sub1 : sub0;

  paddsb_16 u_add (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .sum (sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (xfer) state_d = OUT_FULL;
      OUT_FULL:  if (res_rdy && !xfer) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      sum_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        sum_q <= sum;
        id_q  <= rdy[1];
      end
    end
  end

  assign res_vld = (state_q == OUT_FULL);
  assign res_Sum = sum_q;
  assign res_id  = id_q;

`ifdef PADDSB_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (rdy[0] && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
      if (rdy[1] && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif
endmodule

// File: tb/tb_paddsb_arbiter.sv
module tb_paddsb_arbiter;
  localparam int CW = 4;
`ifdef PADDSB_ARB_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic vld0 = 0, vld1 = 0, sub0 = 0, sub1 = 0, res_rdy = 0;
  logic [15:0] A0 = 0, B0 = 0, A1 = 0, B1 = 0;
  logic rdy0, rdy1, res_vld, res_id;
  logic [15:0] res_Sum;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;

  int total = 0, pass = 0;

  always #5 clk = ~clk;

  paddsb_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vld0(vld0), .vld1(vld1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .sub0(sub0), .sub1(sub1), .rdy0(rdy0), .rdy1(rdy1),
    .res_vld(res_vld), .res_Sum(res_Sum), .res_id(res_id), .res_rdy(res_rdy),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask

  // Per-nibble signed arithmetic, clamped to [-8, 7].
  function automatic logic [15:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      int x, y, r;
      x = int'(a[i*4 +: 4]); if (x > 7) x -= 16;
      y = int'(b[i*4 +: 4]); if (y > 7) y -= 16;
      r = s ? x - y : x + y;
      if (r > 7)  r = 7;
      if (r < -8) r = -8;
      o[i*4 +: 4] = 4'(r);
    end
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; vld0 = 0; vld1 = 0; res_rdy = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic        id;
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[7];

  // random-phase model state
  logic m_vld, m_id, m_last;
  logic [15:0] m_sum;
  int m_c0, m_c1;
  logic took0, took1;

  initial begin
    vt[0] = '{1'b0, 16'h7531, 16'h1111, 1'b0, 16'h7642};
    vt[1] = '{1'b1, 16'h8000, 16'h1000, 1'b1, 16'h8000};
    vt[2] = '{1'b1, 16'h0000, 16'h8000, 1'b1, 16'h7000};
    vt[3] = '{1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345};
    vt[4] = '{1'b1, 16'hFFFF, 16'h1111, 1'b0, 16'h0000};
    vt[5] = '{1'b0, 16'h8888, 16'h1111, 1'b1, 16'h8888};
    vt[6] = '{1'b1, 16'h4321, 16'h1234, 1'b1, 16'h31FD};

    do_reset();
    #1;
    chk("reset res_vld", res_vld, 0);
    chk("reset res_Sum", res_Sum, 0);
    chk("reset res_id", res_id, 0);
    chk("reset gnt_cnt0", gnt_cnt0, 0);
    chk("reset gnt_cnt1", gnt_cnt1, 0);

    // Table vectors: single transfer, result visible after the edge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      res_rdy = 1;
      vld0 = !vt[i].id; vld1 = vt[i].id;
      A0 = vt[i].a; B0 = vt[i].b; sub0 = vt[i].sub;
      A1 = vt[i].a; B1 = vt[i].b; sub1 = vt[i].sub;
      #1;
      chk($sformatf("vec%0d rdy", i), vt[i].id ? rdy1 : rdy0, 1);
      @(posedge clk);
      @(negedge clk);
      vld0 = 0; vld1 = 0;
      #1;
      chk($sformatf("vec%0d res_vld", i), res_vld, 1);
      chk($sformatf("vec%0d res_Sum", i), res_Sum, vt[i].exp);
      chk($sformatf("vec%0d res_id", i), res_id, vt[i].id);
    end

    // Tie after reset: alternates starting with requester 0.
    do_reset();
    A0 = 16'h1111; B0 = 16'h2222; sub0 = 0;
    A1 = 16'h3333; B1 = 16'h1111; sub1 = 1;
    vld0 = 1; vld1 = 1; res_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tie%0d rdy0", k), rdy0, (k % 2) == 0);
      chk($sformatf("tie%0d rdy1", k), rdy1, (k % 2) == 1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tie%0d res_id", k), res_id, k % 2);
      chk($sformatf("tie%0d res_vld", k), res_vld, 1);
    end

    // Backpressure: hold the requester-1 result while 0 waits.
    res_rdy = 0; vld1 = 0;
    vld0 = 1; A0 = 16'h1234; B0 = 16'h1111; sub0 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d rdy0", k), rdy0, 0);
      chk($sformatf("bp%0d rdy1", k), rdy1, 0);
      chk($sformatf("bp%0d res_Sum", k), res_Sum, ref_op(16'h3333, 16'h1111, 1'b1));
      chk($sformatf("bp%0d res_id", k), res_id, 1);
      @(posedge clk);
      @(negedge clk);
    end
    res_rdy = 1;
    #1;
    chk("bp release rdy0", rdy0, 1);
    @(posedge clk);
    @(negedge clk);
    vld0 = 0; res_rdy = 0;
    #1;
    chk("bp new res_Sum", res_Sum, 16'h2345);
    chk("bp new res_id", res_id, 0);

    // Reset mid-op with a held result and pending requests.
    vld1 = 1; A1 = 16'h0101; B1 = 16'h0101; sub1 = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0; vld0 = 1; res_rdy = 1;
    #1;
    chk("rst rdy0", rdy0, 0);
    chk("rst rdy1", rdy1, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst res_vld", res_vld, 0);
    chk("rst res_Sum", res_Sum, 0);
    chk("rst gnt_cnt0", gnt_cnt0, 0);
    chk("rst gnt_cnt1", gnt_cnt1, 0);
    chk("rst tie rdy0", rdy0, 1);
    chk("rst tie rdy1", rdy1, 0);

    // Counter saturation: 17 transfers on requester 0.
    do_reset();
    vld0 = 1; vld1 = 0; res_rdy = 1;
    repeat (17) @(posedge clk);
    @(negedge clk);
    vld0 = 0;
    #1;
    chk("cnt gnt_cnt0", gnt_cnt0, CNT_ON ? 32'hF : 32'h0);
    chk("cnt gnt_cnt1", gnt_cnt1, 0);

    // Randomized traffic against a behavioural model.
    do_reset();
    m_vld = 0; m_id = 0; m_last = 1; m_sum = 0; m_c0 = 0; m_c1 = 0;
    took0 = 1; took1 = 1;
    for (int c = 0; c < 400; c++) begin
      logic free, w0, w1, e0, e1;
      @(negedge clk);
      if (!vld0 || took0) begin
        vld0 = 1'($urandom_range(0, 1)); A0 = 16'($urandom); B0 = 16'($urandom); sub0 = 1'($urandom);
      end
      if (!vld1 || took1) begin
        vld1 = 1'($urandom_range(0, 1)); A1 = 16'($urandom); B1 = 16'($urandom); sub1 = 1'($urandom);
      end
      res_rdy = ($urandom_range(0, 3) != 0);
      #1;
      free = !m_vld || res_rdy;
      if (vld0 && vld1) begin w0 = m_last; w1 = !m_last; end
      else begin w0 = vld0; w1 = vld1; end
      e0 = w0 && free; e1 = w1 && free;
      chk("rnd rdy0", rdy0, e0);
      chk("rnd rdy1", rdy1, e1);
      chk("rnd res_vld", res_vld, m_vld);
      chk("rnd res_Sum", res_Sum, m_sum);
      chk("rnd res_id", res_id, m_id);
      chk("rnd gnt_cnt0", gnt_cnt0, m_c0);
      chk("rnd gnt_cnt1", gnt_cnt1, m_c1);
      if (e0 || e1) begin
        m_sum  = e1 ? ref_op(A1, B1, sub1) : ref_op(A0, B0, sub0);
        m_id   = e1;
        m_vld  = 1;
        m_last = e1;
        if (CNT_ON && e0 && m_c0 < 15) m_c0++;
        if (CNT_ON && e1 && m_c1 < 15) m_c1++;
      end else if (res_rdy) begin
        m_vld = 0;
      end
      took0 = e0; took1 = e1;
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/paddsb_arbiter.md
PADDSB_ARBITER -- requirements
Module: paddsb_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of per-requester grant counters.
REQ-002 The design SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 vld0, vld1  in  1 each  requester 0/1 operation request.
REQ-006 A0, B0, A1, B1  in  16 each  packed 4x4-bit two's-complement operands.
REQ-007 sub0, sub1  in  1 each  1 = subtract (A-B), 0 = add.
REQ-008 rdy0, rdy1  out  1 each  request accepted this cycle.
REQ-009 res_vld  out  1  result register holds a valid result.
REQ-010 res_Sum  out  16  saturated packed nibble result.
REQ-011 res_id  out  1  requester that owns res_Sum.
REQ-012 res_rdy  in  1  consumer accepts result this cycle.
REQ-013 gnt_cnt0, gnt_cnt1  out  CNT_W each  accepted-request counters.

Function
REQ-014 Transfer on requester i occurs when vld_i & rdy_i at a rising clk edge; requesters SHALL hold vld/A/B/sub stable until transfer.
REQ-015 Output register free = ~res_vld | res_rdy; rdy_i = gnt_i & free; at most one rdy_i high per cycle.
REQ-016 Grant: only one vld -> that requester; both vld -> requester other than last-accepted (round-robin pointer); neither -> no grant.
REQ-017 Pointer SHALL update only on a transfer, to the accepted requester's index.
REQ-018 Datapath per nibble: add/sub of 4-bit two's-complement; positive overflow -> 4'b0111, negative overflow -> 4'b1000, else raw 4-bit result; nibbles independent, no inter-nibble carry.
REQ-019 Latency: result of transfer at edge N SHALL be visible on res_Sum/res_id with res_vld=1 after edge N.
REQ-020 Output states: EMPTY (res_vld=0) and FULL (res_vld=1); EMPTY->FULL on transfer; FULL->FULL on res_rdy & transfer (back-to-back, new data); FULL->EMPTY on res_rdy & no transfer; FULL held with res_Sum/res_id stable while res_rdy=0.
REQ-021 Throughput: one result per cycle when res_rdy held high.
REQ-022 res_rdy while EMPTY SHALL be ignored.

Reset
REQ-023 On rst_n=0 at an edge: res_vld=0, res_Sum=16'h0000, res_id=0, pointer = "last=1" (requester 0 wins first tie), counters=0.
REQ-024 Reset mid-operation SHALL discard any held result; rdy0/rdy1 SHALL be 0 while rst_n=0.

Configuration
REQ-025 Macro PADDSB_ARB_CNT_EN: defined -> gnt_cnt_i increments by 1 on each transfer of requester i, saturating at all-ones; undefined -> counter flops absent, gnt_cnt0/gnt_cnt1 tied to 0, ports retained.

Structure
REQ-026 Package paddsb_arb_pkg SHALL hold: nibble saturation constants (4'b0111, 4'b1000), requester-id type (1 bit), output-state encoding (EMPTY/FULL).
REQ-027 Sub-module rr_arb2: 2-way round-robin grant logic with pointer flop; datapath SHALL instantiate the existing 16-bit saturating packed nibble adder.

Verification
REQ-028 Add: vld0=1, A0=16'h7531, B0=16'h1111, sub0=0 -> next cycle res_vld=1, res_Sum=16'h7642, res_id=0.
REQ-029 Sub: vld1=1, A1=16'h8000, B1=16'h1000, sub1=1 -> res_Sum=16'h8000, res_id=1; A1=16'h0000, B1=16'h8000, sub1=1 -> res_Sum=16'h7000.
REQ-030 Tie after reset: vld0=vld1=1 for 4 cycles, res_rdy=1 -> res_id sequence 0,1,0,1; rdy0/rdy1 alternate, never both high.
REQ-031 Backpressure: res_vld=1, res_rdy=0 for 3 cycles -> res_Sum/res_id unchanged, rdy0=rdy1=0; res_rdy=1 -> pending request accepted same cycle, new result next cycle.
REQ-032 Reset mid-op: rst_n=0 for 1 cycle while res_vld=1 and vld1=1 -> res_vld=0, res_Sum=0, counters 0, next tie grants requester 0.
REQ-033 With PADDSB_ARB_CNT_EN, CNT_W=4: 17 transfers on requester 0 -> gnt_cnt0=4'hF, gnt_cnt1=0; without macro both read 0.
